usb_tx_serializer: RTL

//   Transmit-side counterpart of the USB receive glue. Captures a full wide

---
 rtl/usb_tx_serializer.sv | 118 +++++++++++
 1 files changed

// File: rtl/usb_tx_serializer.sv
// rtl/usb_tx_serializer.sv - wide frame to USB byte stream serializer; optional CRC-16 trailer via TX_CRC_EN
module usb_tx_serializer #(
    parameter int NUM_BYTES = 66
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [NUM_BYTES*8-1:0] tx_data_in,
    input  logic                   tx_load,
    output logic                   tx_busy,
    output logic [7:0]             usb_data_out,
    output logic                   usb_byte_valid,
    input  logic                   usb_byte_ack,
    output logic                   tx_done
);
    localparam int W  = NUM_BYTES * 8;
    localparam int CW = $clog2(NUM_BYTES + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BYTES - 1);

`ifdef TX_CRC_EN
    typedef enum logic [2:0] {IDLE, SEND, CRC_LO, CRC_HI, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, SEND, DONE} state_t;
`endif

    state_t          state_q, state_d;
    logic [W-1:0]    shift_q;
    logic [CW-1:0]   count_q;
    logic            xfer;

`ifdef TX_CRC_EN
    logic [15:0]     crc_q;

    // Reflected CRC-16 (0xA001), one whole byte folded in per call, LSB first
    function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction
`endif

    assign xfer = usb_byte_valid & usb_byte_ack;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (tx_load) state_d = SEND;
            SEND: begin
                if (xfer && count_q == LAST_IDX) begin
`ifdef TX_CRC_EN
                    state_d = CRC_LO;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef TX_CRC_EN
            CRC_LO: if (xfer) state_d = CRC_HI;
            CRC_HI: if (xfer) state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_busy        = (state_q != IDLE);
        tx_done        = (state_q == DONE);
        usb_byte_valid = 1'b0;
        usb_data_out   = 8'h00;
        case (state_q)
            SEND: begin
                usb_byte_valid = 1'b1;
                usb_data_out   = shift_q[W-1 -: 8];
            end
`ifdef TX_CRC_EN
            // Transmitted CRC is the ones' complement of the running register
            CRC_LO: begin
                usb_byte_valid = 1'b1;
                usb_data_out   = ~crc_q[7:0];
            end
            CRC_HI: begin
                usb_byte_valid = 1'b1;
                usb_data_out   = ~crc_q[15:8];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
`ifdef TX_CRC_EN
            crc_q   <= 16'hFFFF;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && tx_load) begin
                shift_q <= tx_data_in;
                count_q <= '0;
`ifdef TX_CRC_EN
                crc_q   <= 16'hFFFF;
`endif
            end else if (state_q == SEND && xfer) begin
                shift_q <= shift_q << 8;
                count_q <= count_q + CW'(1);
`ifdef TX_CRC_EN
                crc_q   <= crc16_step(crc_q, shift_q[W-1 -: 8]);
`endif
            end
        end
    end
endmodule
